// File: rtl/core_apb_master_if.sv
// APB4 bus bundle shared by the core APB initiator and its interconnect.
interface apb_intf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic                  psel;
    logic                  penable;
    logic [ADDR_W-1:0]     paddr;
    logic                  pwrite;
    logic [DATA_W/8-1:0]   pstrb;
    logic [2:0]            pprot;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pstrb, pprot, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/core_apb_master.sv
// APB4 initiator for the core private peripheral space.
// Takes one valid/ready request at a time, runs a SETUP/ACCESS transfer,
// and returns read data / error status on a valid/ready response channel.
// A wait-state timeout aborts transfers to a slave that never asserts pready.
module core_apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    input  logic [2:0]          req_prot,

    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_tout,

    apb_intf.master             m_apb
);

    localparam bit             TOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TERM  = TOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [ADDR_W-1:0]     addr_q;
    logic                  write_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   strb_q;
    logic [2:0]            prot_q;

    logic [CNT_W-1:0]      wait_cnt;
    logic                  tout_hit;

    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic                  tout_q;

    logic                  req_hs;
    logic                  psel_c;
    logic                  penable_c;

    assign req_hs   = (state == IDLE) && req_valid;
    assign tout_hit = TOUT_EN && (wait_cnt == TERM);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded control outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        psel_c    = 1'b0;
        penable_c = 1'b0;
        rsp_valid = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                psel_c    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                // pready is checked first so a completion on the terminal
                // count cycle is treated as a normal transfer.
                if (m_apb.pready || tout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture; these registers drive the APB address/data phase
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            prot_q  <= '0;
        end else if (req_hs) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
            strb_q  <= req_strb;
            prot_q  <= req_prot;
        end
    end

    // Wait-state counter: cleared in SETUP, counts ACCESS cycles without pready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (state == ACCESS && !m_apb.pready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Response capture at completion or timeout abort; held until next transfer ends
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else if (state == ACCESS) begin
            if (m_apb.pready) begin
                rdata_q <= write_q ? '0 : m_apb.prdata;
                err_q   <= m_apb.pslverr;
                tout_q  <= 1'b0;
            end else if (tout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
                tout_q  <= 1'b1;
            end
        end
    end

    assign rsp_rdata     = rdata_q;
    assign rsp_err       = err_q;
    assign rsp_tout      = tout_q;

    assign m_apb.psel    = psel_c;
    assign m_apb.penable = penable_c;
    assign m_apb.paddr   = addr_q;
    assign m_apb.pwrite  = write_q;
    assign m_apb.pwdata  = wdata_q;
    assign m_apb.pprot   = prot_q;
    assign m_apb.pstrb   = write_q ? strb_q : '0;

endmodule
